h80_uart_io: RTL



---
 rtl/h80_uart_io.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/h80_uart_io.sv
// h80 bus UART peripheral: 8N1 transmitter and receiver, each behind a FIFO,
// with a DATA/STATUS register pair and wait_n stretching of bus accesses.
module h80_uart_io #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int BASE_ADDR      = 'h0000,
    parameter int CLK_DIV        = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce_n,
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    input  logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data,
    output logic                      wait_n,
    output logic                      uart_txp,
    input  logic                      uart_rxp
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_DATA = BUS_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_STAT = BUS_ADDR_WIDTH'(BASE_ADDR + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2 - 1);

    typedef enum logic {B_IDLE, B_DONE} bus_st_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;

    bus_st_t bus_q, bus_d;
    rx_st_t  rx_q, rx_d;

    logic         hit, is_stat, is_rd;
    logic         tx_push, tx_pop, rx_push, rx_pop, rd_fire, stat_wr;
    logic [7:0]   rd_q, rd_d, status_v;
    logic         ovr_q, ovr_d, ferr_q, ferr_d, ovr_set, ferr_set;
    logic [7:0]   tx_mem [FIFO_DEPTH];
    logic [7:0]   rx_mem [FIFO_DEPTH];
    logic [PW:0]  tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic         tx_empty, tx_full, rx_empty, rx_full;
    logic         tx_act_q, tx_tick;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q;
    logic [3:0]   tx_bit_q;
    logic [9:0]   tx_sh_q;
    logic         rx_s1_q, rx_s2_q, rx_prev_q, rx_half, rx_tick, rx_done;
    logic [2:0]   rx_bit_q;
    logic [7:0]   rx_sh_q;
    logic         unused_bits;

    assign unused_bits = ^{data[BUS_DATA_WIDTH-1:8], cmd[BUS_CMD_WIDTH-1:1]};

    assign is_stat = (addr == A_STAT);
    assign hit     = !ce_n && ((addr == A_DATA) || is_stat);
    assign is_rd   = cmd[0];

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[PW] != tx_rd_q[PW]) && (tx_wr_q[PW-1:0] == tx_rd_q[PW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[PW] != rx_rd_q[PW]) && (rx_wr_q[PW-1:0] == rx_rd_q[PW-1:0]);

    // Bus FSM: state register, next-state logic, output logic
    always_ff @(posedge clk) begin
        if (reset) bus_q <= B_IDLE;
        else       bus_q <= bus_d;
    end

    always_comb begin
        bus_d = bus_q;
        case (bus_q)
            B_IDLE: if (rd_fire || stat_wr || tx_push) bus_d = B_DONE;
            B_DONE: if (ce_n) bus_d = B_IDLE;
            default: bus_d = B_IDLE;
        endcase
    end

    // A stalled DATA write proceeds in the cycle the TX shifter frees a slot.
    always_comb begin
        wait_n  = 1'b1;
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        rd_fire = 1'b0;
        stat_wr = 1'b0;
        if (bus_q == B_IDLE && hit) begin
            if (is_rd) begin
                wait_n  = 1'b0;
                rd_fire = 1'b1;
                rx_pop  = !is_stat && !rx_empty;
            end else if (is_stat) begin
                stat_wr = 1'b1;
            end else if (tx_full && !tx_pop) begin
                wait_n  = 1'b0;
            end else begin
                tx_push = 1'b1;
            end
        end
    end

    assign data = (bus_q == B_DONE && hit && is_rd) ?
                  {{(BUS_DATA_WIDTH-8){1'b0}}, rd_q} : {BUS_DATA_WIDTH{1'bz}};

    assign status_v = {3'b000, !tx_empty || tx_act_q, ferr_q, ovr_q, !tx_full, !rx_empty};
    assign rd_d     = is_stat ? status_v : (rx_empty ? 8'h00 : rx_mem[rx_rd_q[PW-1:0]]);

    // Sticky flags: a new event on the same edge as a clear wins.
    assign ovr_d  = ovr_set  || (ovr_q  && !((rd_fire && is_stat) || (stat_wr && data[2])));
    assign ferr_d = ferr_set || (ferr_q && !((rd_fire && is_stat) || (stat_wr && data[3])));

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
        end
        if (rd_fire) rd_q <= rd_d;
    end

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
        end
        if (tx_push) tx_mem[tx_wr_q[PW-1:0]] <= data[7:0];
        if (rx_push) rx_mem[rx_wr_q[PW-1:0]] <= rx_sh_q;
    end

    // TX shifter: the next byte loads on the last clock of the stop bit
    assign tx_tick  = (tx_cnt_q == DIV_LAST);
    assign tx_pop   = !tx_empty && (!tx_act_q || (tx_tick && tx_bit_q == 4'd9));
    assign uart_txp = !tx_act_q || tx_sh_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_act_q <= 1'b0;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
        end else if (tx_pop) begin
            tx_act_q <= 1'b1;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
        end else if (tx_act_q) begin
            tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + 1'b1;
            if (tx_tick) begin
                tx_bit_q <= tx_bit_q + 1'b1;
                if (tx_bit_q == 4'd9) tx_act_q <= 1'b0;
            end
        end
        if (tx_pop)                 tx_sh_q <= {1'b1, tx_mem[tx_rd_q[PW-1:0]], 1'b0};
        else if (tx_act_q && tx_tick) tx_sh_q <= {1'b1, tx_sh_q[9:1]};
    end

    // RX FSM: synchroniser and state register, next-state logic, output logic
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_q      <= R_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
        end else begin
            rx_s1_q   <= uart_rxp;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_q      <= rx_d;
            rx_cnt_q  <= (rx_q != rx_d || rx_tick) ? '0 : rx_cnt_q + 1'b1;
            if (rx_q == R_IDLE)                rx_bit_q <= '0;
            else if (rx_q == R_DATA && rx_tick) rx_bit_q <= rx_bit_q + 1'b1;
        end
        if (rx_q == R_DATA && rx_tick) rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
    end

    assign rx_half = (rx_cnt_q == DIV_HALF);
    assign rx_tick = (rx_cnt_q == DIV_LAST);

    always_comb begin
        rx_d = rx_q;
        case (rx_q)
            R_IDLE:  if (rx_prev_q && !rx_s2_q) rx_d = R_START;
            R_START: if (rx_half) rx_d = rx_s2_q ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_d = R_STOP;
            R_STOP:  if (rx_tick) rx_d = R_IDLE;
            default: rx_d = R_IDLE;
        endcase
    end

    always_comb begin
        rx_done  = (rx_q == R_STOP) && rx_tick;
        rx_push  = rx_done && rx_s2_q && (!rx_full || rx_pop);
        ovr_set  = rx_done && rx_s2_q && rx_full && !rx_pop;
        ferr_set = rx_done && !rx_s2_q;
    end
endmodule
